// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with PC, credit-limited requests and prefetch FIFO
`timescale 1ns/1ps
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fetch_en,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [31:0]                  imem_rdata,
    output logic [31:0]                  instr,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic                         instr_valid,
    input  logic                         next_op,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [ADDR_W-1:0] pc;
    logic              rsp_pending;
    logic [ADDR_W-1:0] rsp_addr;
    logic [31:0]       store_instr [DEPTH];
    logic [ADDR_W-1:0] store_pc    [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              pop;
    logic              push;
    logic [CW1-1:0]    committed;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Credit check: entries held plus the one in flight, less this cycle's pop, must leave room.
    always_comb begin
        pop       = (count != '0) && next_op;
        push      = rsp_pending;
        committed = {1'b0, count} + CW1'(rsp_pending) - CW1'(pop);
        imem_req  = reset_n && fetch_en && (committed < CW1'(DEPTH));
    end

    // Head of the FIFO goes to the decoder; zeros when nothing is buffered.
    always_comb begin
        imem_addr   = pc;
        instr_valid = (count != '0);
        instr       = instr_valid ? store_instr[rd_ptr] : 32'd0;
        instr_pc    = instr_valid ? store_pc[rd_ptr] : '0;
        fifo_count  = count;
    end

    // PC, in-flight tracking, pointers and occupancy; reset drops everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            rsp_pending <= 1'b0;
            rsp_addr    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (imem_req) begin
                pc <= pc + ADDR_W'(1);
            end
            rsp_pending <= imem_req;
            rsp_addr    <= pc;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage needs no reset: it is only visible while count says it holds data.
    always_ff @(posedge clk) begin
        if (push) begin
            store_instr[wr_ptr] <= imem_rdata;
            store_pc[wr_ptr]    <= rsp_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (two instances: RESET_PC 0 and 254)
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        next_op = 1'b0;

    logic        req_o   [2];
    logic [7:0]  addr_o  [2];
    logic [31:0] rdata   [2];
    logic [31:0] instr_o [2];
    logic [7:0]  ipc_o   [2];
    logic        valid_o [2];
    logic [1:0]  cnt_o   [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .RESET_PC(8'd0), .DEPTH(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
        .imem_req(req_o[0]), .imem_addr(addr_o[0]), .imem_rdata(rdata[0]),
        .instr(instr_o[0]), .instr_pc(ipc_o[0]), .instr_valid(valid_o[0]),
        .next_op(next_op), .fifo_count(cnt_o[0])
    );

    instr_fetch #(.ADDR_W(8), .RESET_PC(8'd254), .DEPTH(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
        .imem_req(req_o[1]), .imem_addr(addr_o[1]), .imem_rdata(rdata[1]),
        .instr(instr_o[1]), .instr_pc(ipc_o[1]), .instr_valid(valid_o[1]),
        .next_op(next_op), .fifo_count(cnt_o[1])
    );

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return 32'h1000_0000 + {24'd0, a};
    endfunction

    function automatic logic [7:0] rp(input int k);
        return (k == 0) ? 8'd0 : 8'd254;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous instruction memory: data one cycle after the request.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rdata[k] <= req_o[k] ? mem_word(addr_o[k]) : 32'hBAD0_BAD0;
        end
    end

    // Reference model: per instance a next PC, the request in flight and a queue of {pc, word}.
    logic [39:0] mq0[$];
    logic [39:0] mq1[$];
    logic [39:0] mq[$];
    logic [7:0]  mpc    [2];
    bit          mpend  [2];
    logic [7:0]  mpaddr [2];
    bit          rst_seen = 1'b0;
    bit          mpop;
    bit          ereq;
    int          occ;

    always @(negedge reset_n) rst_seen = 1'b1;

    always @(negedge clk) begin
        if (rst_seen) begin
            mq0.delete();
            mq1.delete();
            for (int k = 0; k < 2; k++) begin
                mpc[k]   = rp(k);
                mpend[k] = 1'b0;
            end
            rst_seen = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) mq = mq0; else mq = mq1;
            if (!reset_n) begin
                mq.delete();
                mpc[k]   = rp(k);
                mpend[k] = 1'b0;
                chk($sformatf("dut%0d rst imem_req", k), req_o[k], 0);
                chk($sformatf("dut%0d rst imem_addr", k), addr_o[k], rp(k));
                chk($sformatf("dut%0d rst instr_valid", k), valid_o[k], 0);
                chk($sformatf("dut%0d rst instr", k), instr_o[k], 0);
                chk($sformatf("dut%0d rst instr_pc", k), ipc_o[k], 0);
                chk($sformatf("dut%0d rst fifo_count", k), cnt_o[k], 0);
            end else begin
                mpop = (mq.size() != 0) && next_op;
                occ  = mq.size() + int'(mpend[k]) - int'(mpop);
                ereq = fetch_en && (occ < 2);
                chk($sformatf("dut%0d imem_req", k), req_o[k], ereq);
                chk($sformatf("dut%0d imem_addr", k), addr_o[k], mpc[k]);
                chk($sformatf("dut%0d instr_valid", k), valid_o[k], mq.size() != 0);
                chk($sformatf("dut%0d instr", k), instr_o[k],
                    (mq.size() != 0) ? mq[0][31:0] : 32'd0);
                chk($sformatf("dut%0d instr_pc", k), ipc_o[k],
                    (mq.size() != 0) ? mq[0][39:32] : 8'd0);
                chk($sformatf("dut%0d fifo_count", k), cnt_o[k], mq.size());
                if (mpop) void'(mq.pop_front());
                if (mpend[k]) mq.push_back({mpaddr[k], mem_word(mpaddr[k])});
                mpend[k]  = ereq;
                mpaddr[k] = mpc[k];
                if (ereq) mpc[k] = mpc[k] + 8'd1;
            end
            if (k == 0) mq0 = mq; else mq1 = mq;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_pc;
        int n;
        logic [7:0] ahead;

        // Reset then fetch, with the wrap instance running alongside.
        fetch_en = 1'b1;
        next_op  = 1'b1;
        step();
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk("t1 c1 req", req_o[0], 1);
        chk("t1 c1 addr", addr_o[0], 8'd0);
        chk("t4 c1 addr", addr_o[1], 8'd254);
        step(); #1;
        chk("t1 c2 addr", addr_o[0], 8'd1);
        chk("t1 c2 valid", valid_o[0], 0);
        chk("t4 c2 addr", addr_o[1], 8'd255);
        step(); #1;
        chk("t1 c3 valid", valid_o[0], 1);
        chk("t1 c3 instr", instr_o[0], 32'h1000_0000);
        chk("t1 c3 pc", ipc_o[0], 8'd0);
        chk("t4 c3 addr", addr_o[1], 8'd0);
        chk("t4 c3 pc", ipc_o[1], 8'd254);
        chk("t4 c3 instr", instr_o[1], 32'h1000_00FE);
        step(); #1;
        chk("t1 c4 instr", instr_o[0], 32'h1000_0001);
        chk("t4 c4 pc", ipc_o[1], 8'd255);
        chk("t4 c4 addr", addr_o[1], 8'd1);
        step(); #1;
        chk("t4 c5 pc", ipc_o[1], 8'd0);
        chk("t4 c5 instr", instr_o[1], 32'h1000_0000);
        step(); #1;
        chk("t4 c6 pc", ipc_o[1], 8'd1);
        repeat (4) step();

        // Backpressure from the start.
        next_op = 1'b0;
        do_reset();
        #1;
        chk("t2 c1 req", req_o[0], 1);
        chk("t2 c1 addr", addr_o[0], 8'd0);
        step(); #1;
        chk("t2 c2 req", req_o[0], 1);
        chk("t2 c2 addr", addr_o[0], 8'd1);
        step(); #1;
        chk("t2 c3 req", req_o[0], 0);
        step();
        step(); #1;
        chk("t2 c5 count", cnt_o[0], 2'd2);
        chk("t2 c5 req", req_o[0], 0);
        chk("t2 c5 instr", instr_o[0], 32'h1000_0000);
        step();
        next_op = 1'b1;
        #1;
        chk("t2 pop req", req_o[0], 1);
        chk("t2 pop addr", addr_o[0], 8'd2);
        step();
        next_op = 1'b0;
        #1;
        chk("t2 after req", req_o[0], 0);
        chk("t2 after instr", instr_o[0], 32'h1000_0001);
        chk("t2 after count", cnt_o[0], 2'd1);

        // Decoder-style handshake: one pop every fourth cycle.
        do_reset();
        exp_pc = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            next_op = (i % 4 == 3);
            #1;
            if (next_op && valid_o[0]) begin
                chk("t3 pop pc", ipc_o[0], exp_pc[7:0]);
                chk("t3 pop instr", instr_o[0], mem_word(exp_pc[7:0]));
                exp_pc++;
            end
            if (valid_o[0]) begin
                ahead = addr_o[0] - ipc_o[0];
                chk("t3 pc ahead", ahead <= 8'd3, 1);
            end
        end
        chk("t3 pops", exp_pc, 12);

        // Fetch stall after the request to address 5.
        next_op  = 1'b1;
        fetch_en = 1'b1;
        do_reset();
        #1;
        n = 0;
        while (!(req_o[0] && addr_o[0] == 8'd5) && n < 20) begin
            step(); #1;
            n++;
        end
        chk("t5 saw req 5", n < 20, 1);
        step();
        fetch_en = 1'b0;
        #1;
        chk("t5 stall req", req_o[0], 0);
        step(); #1;
        chk("t5 valid 5", valid_o[0], 1);
        chk("t5 pc 5", ipc_o[0], 8'd5);
        chk("t5 instr 5", instr_o[0], 32'h1000_0005);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("t5 idle req", req_o[0], 0);
            chk("t5 idle valid", valid_o[0], 0);
        end
        step();
        fetch_en = 1'b1;
        #1;
        chk("t5 resume req", req_o[0], 1);
        chk("t5 resume addr", addr_o[0], 8'd6);

        // Reset pulse in mid-stream; stale response must be dropped.
        repeat (4) step();
        #1;
        chk("t6 pre count", cnt_o[0], 2'd1);
        step();
        reset_n = 1'b0;
        #1;
        chk("t6 imm req", req_o[0], 0);
        chk("t6 imm valid", valid_o[0], 0);
        chk("t6 imm instr", instr_o[0], 0);
        chk("t6 imm pc", ipc_o[0], 0);
        chk("t6 imm count", cnt_o[0], 0);
        chk("t6 imm addr1", addr_o[1], 8'd254);
        #1;
        reset_n = 1'b1;
        #1;
        chk("t6 rel req", req_o[0], 1);
        chk("t6 rel addr", addr_o[0], 8'd0);
        step(); #1;
        chk("t6 stale dropped", valid_o[0], 0);
        chk("t6 stale count", cnt_o[0], 0);
        step(); #1;
        chk("t6 first valid", valid_o[0], 1);
        chk("t6 first pc", ipc_o[0], 8'd0);
        chk("t6 first instr", instr_o[0], 32'h1000_0000);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
